// File: rtl/alu_arbiter_pkg.sv
// Shared constants, opcode values and arbiter state type for the ALU arbiter slice.
package alu_arbiter_pkg;

  localparam int unsigned WORD_SIZE       = 19;
  localparam int unsigned OPCODE_SIZE     = 4;
  localparam int unsigned ALU_ARB_NUM_REQ = 2;

  typedef logic [OPCODE_SIZE-1:0] opcode_t;
  typedef logic [WORD_SIZE-1:0]   word_t;

  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_MUL = 4'd2;
  localparam opcode_t OP_DIV = 4'd3;
  localparam opcode_t OP_INC = 4'd4;
  localparam opcode_t OP_DEC = 4'd5;
  localparam opcode_t OP_AND = 4'd6;
  localparam opcode_t OP_OR  = 4'd7;
  localparam opcode_t OP_XOR = 4'd8;
  localparam opcode_t OP_NOT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  function automatic logic is_muldiv(opcode_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/ALU bus of the ALU arbiter; resp_err exists only with ALU_ARB_DIVZERO_CHECK_EN.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [ALU_ARB_NUM_REQ-1:0] req_valid;
  logic [ALU_ARB_NUM_REQ-1:0] req_ready;
  opcode_t                    req_op_0;
  opcode_t                    req_op_1;
  word_t                      req_a_0;
  word_t                      req_a_1;
  word_t                      req_b_0;
  word_t                      req_b_1;
  logic [ALU_ARB_NUM_REQ-1:0] resp_valid;
  word_t                      resp_data;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
  logic                       resp_err;
`endif
  opcode_t                    alu_op;
  word_t                      alu_a;
  word_t                      alu_b;
  word_t                      alu_result;

  modport slave (
    input  req_valid, req_op_0, req_op_1, req_a_0, req_a_1, req_b_0, req_b_1,
    input  alu_result,
`ifdef ALU_ARB_DIVZERO_CHECK_EN
    output resp_err,
`endif
    output req_ready, resp_valid, resp_data, alu_op, alu_a, alu_b
  );

  modport master (
    output req_valid, req_op_0, req_op_1, req_a_0, req_a_1, req_b_0, req_b_1,
    output alu_result,
`ifdef ALU_ARB_DIVZERO_CHECK_EN
    input  resp_err,
`endif
    input  req_ready, resp_valid, resp_data, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, on contention the one not granted last wins.
module alu_rr_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_ARB_NUM_REQ-1:0] req_valid_i,
  input  logic                       last_grant_i,
  output logic [ALU_ARB_NUM_REQ-1:0] grant_o,
  output logic                       grant_idx_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = 1'b0;
    case (req_valid_i)
      2'b01: begin
        grant_o     = 2'b01;
        grant_idx_o = 1'b0;
      end
      2'b10: begin
        grant_o     = 2'b10;
        grant_idx_o = 1'b1;
      end
      2'b11: begin
        grant_idx_o = ~last_grant_i;
        grant_o     = last_grant_i ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; IDLE -> BUSY -> DONE sequencing with opcode-dependent latency.
// Optional ALU_ARB_DIVZERO_CHECK_EN short-circuits DIV by zero to an all-ones error response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned ALU_LATENCY    = 1,
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MULDIV_LATENCY + 1);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] count_q, count_d;
  opcode_t          alu_op_q, alu_op_d;
  word_t            alu_a_q, alu_a_d;
  word_t            alu_b_q, alu_b_d;
  word_t            resp_data_q, resp_data_d;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
  logic             err_q, err_d;
`endif

  logic [ALU_ARB_NUM_REQ-1:0] grant;
  logic                       grant_idx;
  opcode_t                    sel_op;
  word_t                      sel_a;
  word_t                      sel_b;
  logic [CNT_W-1:0]           sel_lat;

  alu_rr_arbiter u_rr (
    .req_valid_i  (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  assign sel_op  = grant_idx ? bus.req_op_1 : bus.req_op_0;
  assign sel_a   = grant_idx ? bus.req_a_1  : bus.req_a_0;
  assign sel_b   = grant_idx ? bus.req_b_1  : bus.req_b_0;
  assign sel_lat = is_muldiv(sel_op) ? CNT_W'(MULDIV_LATENCY) : CNT_W'(ALU_LATENCY);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    count_d      = count_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_data_d  = resp_data_q;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
          // Divide by zero never reaches the ALU; alu_* keep the previous operation.
          if (sel_op == OP_DIV && sel_b == '0) begin
            resp_data_d = '1;
            err_d       = 1'b1;
            state_d     = DONE;
          end else begin
            err_d    = 1'b0;
            alu_op_d = sel_op;
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            count_d  = sel_lat;
            state_d  = BUSY;
          end
`else
          alu_op_d = sel_op;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          count_d  = sel_lat;
          state_d  = BUSY;
`endif
        end
      end
      BUSY: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          resp_data_d = bus.alu_result;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      count_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_data_q  <= '0;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      count_q      <= count_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_data_q  <= resp_data_d;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE) ? grant : '0;
  assign bus.resp_valid = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : '0;
  assign bus.resp_data  = resp_data_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
  assign bus.resp_err   = (state_q == DONE) && err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a combinational ALU model on the alu_* bus.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(
    .ALU_LATENCY    (1),
    .MULDIV_LATENCY (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic word_t alu_model(opcode_t op, word_t a, word_t b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == '0) ? '0 : a / b;
      OP_INC:  return a + 19'd1;
      OP_DEC:  return a - 19'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      default: return a + b + 19'd100;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic idx, input opcode_t op, input word_t a, input word_t b);
    if (idx) begin
      bus.req_op_1 = op; bus.req_a_1 = a; bus.req_b_1 = b;
    end else begin
      bus.req_op_0 = op; bus.req_a_0 = a; bus.req_b_0 = b;
    end
  endtask

  task automatic run_op(input logic idx, input opcode_t op, input word_t a, input word_t b,
                        input int lat, input word_t expv);
    logic [1:0] oh;
    oh = idx ? 2'b10 : 2'b01;
    set_req(idx, op, a, b);
    bus.req_valid = oh;
    #1 check("accept_ready", 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < lat; k++) begin
      check("busy_resp_valid", 32'(bus.resp_valid), 32'(2'b00));
      check("busy_ready", 32'(bus.req_ready), 32'(2'b00));
      check("busy_alu_op", 32'(bus.alu_op), 32'(op));
      check("busy_alu_a", 32'(bus.alu_a), 32'(a));
      check("busy_alu_b", 32'(bus.alu_b), 32'(b));
      tick();
    end
    check("resp_valid", 32'(bus.resp_valid), 32'(oh));
    check("resp_data", 32'(bus.resp_data), 32'(expv));
`ifdef ALU_ARB_DIVZERO_CHECK_EN
    check("resp_err_clear", 32'(bus.resp_err), 32'(1'b0));
`endif
    tick();
    check("resp_pulse_end", 32'(bus.resp_valid), 32'(2'b00));
    check("resp_data_held", 32'(bus.resp_data), 32'(expv));
  endtask

  initial begin
    logic exp_idx;
    rst = 1'b1;
    bus.req_valid = '0;
    set_req(1'b0, '0, '0, '0);
    set_req(1'b1, '0, '0, '0);
    tick();
    tick();
    check("rst_ready", 32'(bus.req_ready), 32'(2'b00));
    check("rst_resp_valid", 32'(bus.resp_valid), 32'(2'b00));
    check("rst_resp_data", 32'(bus.resp_data), 32'(0));
    check("rst_alu_op", 32'(bus.alu_op), 32'(0));
    check("rst_alu_a", 32'(bus.alu_a), 32'(0));
    check("rst_alu_b", 32'(bus.alu_b), 32'(0));
    rst = 1'b0;
    tick();
    check("idle_no_valid_ready", 32'(bus.req_ready), 32'(2'b00));

    run_op(1'b0, OP_ADD, 19'd10, 19'd5, 1, 19'd15);
    run_op(1'b1, OP_MUL, 19'd3, 19'd4, 4, 19'd12);

    // Both requesters held valid: grants alternate starting with requester 0.
    set_req(1'b0, OP_SUB, 19'd10, 19'd5);
    set_req(1'b1, OP_DEC, 19'd10, 19'd0);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_idx = 1'(i % 2);
      #1 check("alt_ready", 32'(bus.req_ready), 32'(exp_idx ? 2'b10 : 2'b01));
      tick();
      check("alt_busy_ready", 32'(bus.req_ready), 32'(2'b00));
      tick();
      check("alt_resp_valid", 32'(bus.resp_valid), 32'(exp_idx ? 2'b10 : 2'b01));
      check("alt_resp_data", 32'(bus.resp_data), 32'(exp_idx ? 19'd9 : 19'd5));
      tick();
    end
    bus.req_valid = '0;

    set_req(1'b1, OP_DIV, 19'd20, 19'd4);
    bus.req_valid = 2'b10;
    #1 check("div_ready", 32'(bus.req_ready), 32'(2'b10));
    tick();
    set_req(1'b0, OP_ADD, 19'd1, 19'd1);
    bus.req_valid = 2'b01;
    #1 check("blocked_ready_1", 32'(bus.req_ready), 32'(2'b00));
    tick();
    check("blocked_ready_2", 32'(bus.req_ready), 32'(2'b00));
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    check("div_resp_valid", 32'(bus.resp_valid), 32'(2'b10));
    check("div_resp_data", 32'(bus.resp_data), 32'(5));
    tick();
    check("div_after_valid", 32'(bus.resp_valid), 32'(2'b00));
    check("withdrawn_no_busy", 32'(bus.alu_op), 32'(OP_DIV));

    set_req(1'b0, OP_XOR, 19'd5, 19'd3);
    bus.req_valid = 2'b01;
    #1 check("xor_ready", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    check("midrst_resp_data", 32'(bus.resp_data), 32'(0));
    check("midrst_alu_op", 32'(bus.alu_op), 32'(0));
    check("midrst_alu_a", 32'(bus.alu_a), 32'(0));
    check("midrst_alu_b", 32'(bus.alu_b), 32'(0));
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'(2'b00));
    tick();
    check("midrst_no_resp", 32'(bus.resp_valid), 32'(2'b00));
    rst = 1'b0;
    tick();
    check("postrst_no_resp", 32'(bus.resp_valid), 32'(2'b00));

    run_op(1'b0, OP_NOT, 19'b1010101010101010101, 19'd0, 1, 19'b0101010101010101010);
    run_op(1'b1, 4'hF, 19'd7, 19'd8, 1, 19'd115);

`ifdef ALU_ARB_DIVZERO_CHECK_EN
    set_req(1'b0, OP_DIV, 19'd20, 19'd0);
    bus.req_valid = 2'b01;
    #1 check("dz_ready", 32'(bus.req_ready), 32'(2'b01));
    tick();
    bus.req_valid = '0;
    check("dz_resp_valid", 32'(bus.resp_valid), 32'(2'b01));
    check("dz_resp_data", 32'(bus.resp_data), 32'(19'h7FFFF));
    check("dz_resp_err", 32'(bus.resp_err), 32'(1'b1));
    check("dz_alu_op_kept", 32'(bus.alu_op), 32'(4'hF));
    check("dz_alu_a_kept", 32'(bus.alu_a), 32'(7));
    check("dz_alu_b_kept", 32'(bus.alu_b), 32'(8));
    tick();
    check("dz_pulse_end", 32'(bus.resp_valid), 32'(2'b00));
    check("dz_err_end", 32'(bus.resp_err), 32'(1'b0));
`else
    run_op(1'b0, OP_DIV, 19'd20, 19'd0, 4, 19'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
